// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program sequencer for the 4-bit core family. It combines three parts:
//   - a polynomial (LFSR) page-low counter,
//   - a return-address stack with depth tracking,
//   - a pending-page latch.
// Every update is strobe-driven on a single clock.
//
// Parameters
//   PL_W      width of the page-low (LFSR) field
//   PU_W      width of the page field
//   DEPTH     number of return-stack entries (>= 1)
//   TAP       second feedback tap, feedback = XNOR(PL[0], PL[TAP])
//   CALL_PAGE page loaded by call when no page is armed
//   OVF_MODE  0 = SHIFT (drop oldest / replicate bottom, one-cycle flags)
//             1 = GUARD (refuse the operation, sticky flags)
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   step         advance the page-low LFSR
//   jmp          load page-low from addr_in (page from pending if armed)
//   call         push current PC, then load {page, addr_in}
//   ret          pop PC from the stack
//   ssp          latch page_in as the pending page and arm it
//   clr_err      clear sticky ovf/unf (GUARD mode)
//   addr_in      jump/call target within the page
//   page_in      page value for ssp
//   pc_out       registered {PU, PL}
//   stk_top      current top-of-stack entry
//   sp_depth     number of valid stack entries
//   page_armed   a pending page is armed
//   ovf, unf     stack overflow / underflow flags
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PL_W      = 6,
  parameter int              PU_W      = 4,
  parameter int              DEPTH     = 5,
  parameter int              TAP       = 1,
  parameter logic [PU_W-1:0] CALL_PAGE = '1,
  parameter int              OVF_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step,
  input  logic                       jmp,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       ssp,
  input  logic                       clr_err,
  input  logic [PL_W-1:0]            addr_in,
  input  logic [PU_W-1:0]            page_in,
  output logic [PU_W+PL_W-1:0]       pc_out,
  output logic [PU_W+PL_W-1:0]       stk_top,
  output logic [$clog2(DEPTH+1)-1:0] sp_depth,
  output logic                       page_armed,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PC_W = PU_W + PL_W;
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam bit GUARD = (OVF_MODE != 0);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PL_W-1:0] pl_q, pl_d;
  logic [PU_W-1:0] pu_q, pu_d;
  logic [PC_W-1:0] stk_q [DEPTH];
  logic [PC_W-1:0] stk_d [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [PU_W-1:0] pend_q, pend_d;
  logic            armed_q, armed_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [PC_W-1:0] pc_cur;
  logic [PL_W-1:0] pl_step;
  logic [PC_W-1:0] stk_push [DEPTH];
  logic [PC_W-1:0] stk_pop  [DEPTH];
  logic            stk_full;
  logic            stk_empty;
  logic            ovf_err;
  logic            unf_err;

  assign pc_cur    = {pu_q, pl_q};
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);

  // XNOR feedback enters at the MSB. The all-ones state maps to itself,
  // which is the expected lockup behaviour and is left alone.
  assign pl_step = {~(pl_q[0] ^ pl_q[TAP]), pl_q[PL_W-1:1]};

  // -------------------------------------------------------------------------
  // Candidate stack images for a push and a pop.
  // Push moves every entry one place toward the bottom and drops the last.
  // Pop moves every entry one place toward the top; the bottom keeps its
  // value, so an emptied stack ends up filled with copies of the bottom.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stk
    if (gi == 0) begin : g_push_head
      assign stk_push[gi] = pc_cur;
    end else begin : g_push_body
      assign stk_push[gi] = stk_q[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_pop_tail
      assign stk_pop[gi] = stk_q[gi];
    end else begin : g_pop_body
      assign stk_pop[gi] = stk_q[gi+1];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Priority is ret > call > jmp > step; only the winner
  // touches the PC and the stack. ssp is evaluated afterwards so that it
  // always wins the armed state, while a coincident jmp/call still sees the
  // old pending page through pend_q/armed_q.
  // -------------------------------------------------------------------------
  always_comb begin
    pl_d    = pl_q;
    pu_d    = pu_q;
    stk_d   = stk_q;
    sp_d    = sp_q;
    pend_d  = pend_q;
    armed_d = armed_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;

    if (ret) begin
      unf_err = stk_empty;
      armed_d = 1'b0;
      // GUARD refuses an empty pop outright: PC and stack stay put.
      if (!(GUARD && stk_empty)) begin
        {pu_d, pl_d} = stk_q[0];
        stk_d        = stk_pop;
        if (!stk_empty) begin
          sp_d = sp_q - SP_ONE;
        end
      end
    end else if (call) begin
      ovf_err = stk_full;
      armed_d = 1'b0;
      pu_d    = armed_q ? pend_q : CALL_PAGE;
      pl_d    = addr_in;
      // The jump always happens; only the push can be refused.
      if (!(GUARD && stk_full)) begin
        stk_d = stk_push;
        if (!stk_full) begin
          sp_d = sp_q + SP_ONE;
        end
      end
    end else if (jmp) begin
      armed_d = 1'b0;
      pu_d    = armed_q ? pend_q : pu_q;
      pl_d    = addr_in;
    end else if (step) begin
      pl_d = pl_step;
    end

    if (ssp) begin
      pend_d  = page_in;
      armed_d = 1'b1;
    end

    // GUARD flags are sticky; a new error beats a coincident clear.
    // SHIFT flags are plain one-cycle pulses.
    ovf_d = ovf_err | (GUARD & ovf_q & ~clr_err);
    unf_d = unf_err | (GUARD & unf_q & ~clr_err);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_q    <= '0;
      pu_q    <= '0;
      sp_q    <= '0;
      pend_q  <= '0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      pl_q    <= pl_d;
      pu_q    <= pu_d;
      sp_q    <= sp_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= stk_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc_out     = pc_cur;
  assign stk_top    = stk_q[0];
  assign sp_depth   = sp_q;
  assign page_armed = armed_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Drives two sequencers with identical strobes:
//   - u_shift: default parameters (DEPTH 5, SHIFT policy)
//   - u_guard: DEPTH 2, GUARD policy
//
// The stimulus process advances a list-level reference model for each
// instance and queues the expected post-edge state. A monitor pops the
// queue each cycle and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, ssp = 1'b0, clr_err = 1'b0;
  logic [5:0] addr_in = '0;
  logic [3:0] page_in = '0;

  logic [9:0] s_pc, s_top, g_pc, g_top;
  logic [2:0] s_dep;
  logic [1:0] g_dep;
  logic       s_armed, s_ovf, s_unf, g_armed, g_ovf, g_unf;

  always #5 clk = ~clk;

  pc_sequencer u_shift (
    .clk(clk), .rst_n(rst_n), .step(step), .jmp(jmp), .call(call), .ret(ret),
    .ssp(ssp), .clr_err(clr_err), .addr_in(addr_in), .page_in(page_in),
    .pc_out(s_pc), .stk_top(s_top), .sp_depth(s_dep), .page_armed(s_armed),
    .ovf(s_ovf), .unf(s_unf)
  );

  pc_sequencer #(.DEPTH(2), .OVF_MODE(1)) u_guard (
    .clk(clk), .rst_n(rst_n), .step(step), .jmp(jmp), .call(call), .ret(ret),
    .ssp(ssp), .clr_err(clr_err), .addr_in(addr_in), .page_in(page_in),
    .pc_out(g_pc), .stk_top(g_top), .sp_depth(g_dep), .page_armed(g_armed),
    .ovf(g_ovf), .unf(g_unf)
  );

  // Reference model state: stk[0] is the top of the return stack.
  typedef struct packed {
    logic [9:0]      pc;
    logic [4:0][9:0] stk;
    logic [2:0]      dep;
    logic [3:0]      pend;
    logic            armed;
    logic            ovf;
    logic            unf;
  } mst_t;

  typedef struct packed {
    mst_t s;
    mst_t g;
  } exp_t;

  mst_t ms, mg;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural rules: priority ret > call > jmp > step, then ssp re-arms.
  function automatic mst_t model_next(input mst_t s, input int cap, input bit guard,
                                      input logic st, input logic jm, input logic ca,
                                      input logic re, input logic sp, input logic cl,
                                      input logic [5:0] a, input logic [3:0] p);
    mst_t n;
    int pl, pu, fb;
    n  = s;
    pu = int'(s.pc[9:6]);
    pl = int'(s.pc[5:0]);
    n.ovf = guard & s.ovf & ~cl;
    n.unf = guard & s.unf & ~cl;
    if (re) begin
      n.armed = 1'b0;
      if (s.dep == 3'd0) begin
        n.unf = 1'b1;
        if (!guard) n.pc = s.stk[0];
      end else begin
        n.pc = s.stk[0];
        for (int i = 0; i < cap - 1; i++) n.stk[i] = s.stk[i+1];
        n.dep = 3'(s.dep - 3'd1);
      end
    end else if (ca) begin
      n.pc    = {(s.armed ? s.pend : 4'hF), a};
      n.armed = 1'b0;
      if (int'(s.dep) == cap) begin
        n.ovf = 1'b1;
        if (!guard) begin
          for (int i = cap - 1; i > 0; i--) n.stk[i] = s.stk[i-1];
          n.stk[0] = s.pc;
        end
      end else begin
        for (int i = cap - 1; i > 0; i--) n.stk[i] = s.stk[i-1];
        n.stk[0] = s.pc;
        n.dep    = 3'(s.dep + 3'd1);
      end
    end else if (jm) begin
      n.pc    = {(s.armed ? s.pend : s.pc[9:6]), a};
      n.armed = 1'b0;
    end else if (st) begin
      fb   = ((pl ^ (pl >> 1)) & 1) ^ 1;
      n.pc = 10'((pu << 6) | (fb << 5) | (pl >> 1));
    end
    if (sp) begin
      n.pend  = p;
      n.armed = 1'b1;
    end
    return n;
  endfunction

  // Called at a falling edge; applies strobes for the next rising edge.
  task automatic drive(input logic st, input logic jm, input logic ca, input logic re,
                       input logic sp, input logic cl, input logic [5:0] a,
                       input logic [3:0] p);
    exp_t e;
    step = st; jmp = jm; call = ca; ret = re; ssp = sp; clr_err = cl;
    addr_in = a; page_in = p;
    ms = model_next(ms, 5, 1'b0, st, jm, ca, re, sp, cl, a, p);
    mg = model_next(mg, 2, 1'b1, st, jm, ca, re, sp, cl, a, p);
    e.s = ms;
    e.g = mg;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 4'h0);
  endtask

  // Asserted at a falling edge; state must clear without waiting for clk.
  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    step = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; ssp = 1'b0; clr_err = 1'b0;
    #1;
    check("rst_now_shift_pc", int'(s_pc), 0);
    check("rst_now_shift_top", int'(s_top), 0);
    check("rst_now_shift_dep", int'(s_dep), 0);
    check("rst_now_guard_dep", int'(g_dep), 0);
    ms = '0;
    mg = '0;
    e.s = ms;
    e.g = mg;
    exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one comparison set per rising edge that has an expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      check("shift_pc", int'(s_pc), int'(e.s.pc));
      check("shift_top", int'(s_top), int'(e.s.stk[0]));
      check("shift_dep", int'(s_dep), int'(e.s.dep));
      check("shift_armed", int'(s_armed), int'(e.s.armed));
      check("shift_ovf", int'(s_ovf), int'(e.s.ovf));
      check("shift_unf", int'(s_unf), int'(e.s.unf));
      check("guard_pc", int'(g_pc), int'(e.g.pc));
      check("guard_top", int'(g_top), int'(e.g.stk[0]));
      check("guard_dep", int'(g_dep), int'(e.g.dep));
      check("guard_armed", int'(g_armed), int'(e.g.armed));
      check("guard_ovf", int'(g_ovf), int'(e.g.ovf));
      check("guard_unf", int'(g_unf), int'(e.g.unf));
      $display("txn %0d: shift pc=%03h dep=%0d ovf=%0d unf=%0d | guard pc=%03h dep=%0d ovf=%0d unf=%0d",
               n_txn, s_pc, s_dep, s_ovf, s_unf, g_pc, g_dep, g_ovf, g_unf);
    end
  end

  initial begin
    ms = '0;
    mg = '0;
    @(negedge clk);
    do_reset();

    // LFSR sequence from reset, then the all-ones lockup state.
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 4'h0);
    check("step_seq", int'(s_pc), 'h03C);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 4'h0);
    check("lockup", int'(s_pc), 'h03F);

    // Armed page jump, plain jump, call and return.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0, 4'h3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 4'h0);
    check("jmp_armed_pc", int'(s_pc), 'h0D5);
    check("jmp_disarm", int'(s_armed), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 4'h0);
    check("jmp_plain_pc", int'(s_pc), 'h0C1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h02, 4'h0);
    check("call_pc", int'(s_pc), 'h3C2);
    check("call_top", int'(s_top), 'h0D5);
    check("call_dep", int'(s_dep), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0, 4'h0);
    check("ret_pc", int'(s_pc), 'h0D5);
    check("ret_dep", int'(s_dep), 0);

    // Six calls from distinct PCs, then six returns: overflow and underflow.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'(6'h10 + k), 4'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'(6'h20 + k), 4'h0);
    end
    check("guard_ovf_sticky", int'(g_ovf), 1);
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0, 4'h0);
    check("shift_unf_repl_pc", int'(s_pc), 'h3D1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h0, 4'h0);

    // call and ret together at depth 1: ret wins, no push.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h07, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h09, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h0A, 4'h0);
    check("callret_pc", int'(s_pc), 'h3C7);
    check("callret_dep", int'(s_dep), 0);

    // ssp coinciding with call and with ret.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h11, 4'h5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 4'h6);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22, 4'h0);

    // Build depth 3 and reset mid-operation.
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 4'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'(6'h30), 4'h0);
    end
    check("pre_reset_dep", int'(s_dep), 3);
    do_reset();

    // Randomized strobes, including coincident ones and rare resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 7) == 0),
              6'($urandom), 4'($urandom));
      end
    end

    idle();
    check("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
